// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch controller.
// Buffer entries carry the fetch PC alongside the instruction word.
package pc_fetch_ctrl_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC_DEF = 32'h0040_0000;
  localparam logic [ADDR_W-1:0] PC_STEP      = 32'd4;
  localparam logic [ADDR_W-1:0] ADDR_MASK    = 32'hFFFF_FFFC;
  localparam logic [1:0]        FIFO_DEPTH   = 2'd2;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_ent_t;

endpackage

// File: rtl/pc_fetch_ctrl_fetch_fifo.sv
// Two-entry FIFO with flush; head is visible combinationally, push-to-head is one cycle.
// The caller never pushes when full; flush wins over same-cycle push/pop.
module fetch_fifo #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic [1:0]   cnt,
  output logic [1:0]   cnt_nxt
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   cnt_q, cnt_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      cnt_d    = 2'd0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign cnt      = cnt_q;
  assign cnt_nxt  = cnt_d;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch controller: loads the PC, fetches over req/ack, buffers two tagged words for decode.
// One instruction per cycle with a zero-wait memory; stops requesting while the buffer is full.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_q,
  output logic [ADDR_W-1:0] pc_d,
  output logic              pc_ena,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] drain_addr_q, drain_addr_d;
  logic              redir;
  logic              push, pop, flush;
  logic [1:0]        fifo_cnt, fifo_cnt_nxt;
  fetch_ent_t        push_ent, head_ent;

  assign redir    = redirect && (state_q != BOOT);
  assign push_ent = {pc_q, imem_rdata};

  fetch_fifo #(.W($bits(fetch_ent_t))) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .push     (push),
    .push_dat (push_ent),
    .pop      (pop),
    .head_dat (head_ent),
    .cnt      (fifo_cnt),
    .cnt_nxt  (fifo_cnt_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= BOOT;
      drain_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      drain_addr_q <= drain_addr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    drain_addr_d = drain_addr_q;
    case (state_q)
      BOOT:  state_d = FETCH;
      FETCH: begin
        // The outstanding request still lands on the old address; remember it for DRAIN.
        if (redir && !imem_ack) begin
          state_d      = DRAIN;
          drain_addr_d = pc_q;
        end else if (!redir && imem_ack && (fifo_cnt_nxt == FIFO_DEPTH)) begin
          state_d = HOLD;
        end
      end
      HOLD:    if (redir || (fifo_cnt_nxt < FIFO_DEPTH)) state_d = FETCH;
      DRAIN:   if (imem_ack) state_d = FETCH;
      default: state_d = BOOT;
    endcase
  end

  // Everything is gated by rst so a mid-fetch reset drops the request without a clock.
  always_comb begin
    pc_ena    = 1'b0;
    pc_d      = '0;
    imem_req  = 1'b0;
    imem_addr = '0;
    push      = 1'b0;
    pop       = 1'b0;
    flush     = 1'b0;
    if (rst) begin
      flush = redir;
      pop   = inst_valid && inst_ready && !redir;
      case (state_q)
        BOOT: begin
          pc_ena = 1'b1;
          pc_d   = RESET_PC & ADDR_MASK;
        end
        FETCH: begin
          imem_req  = 1'b1;
          imem_addr = pc_q;
          if (imem_ack && !redir) begin
            push   = 1'b1;
            pc_ena = 1'b1;
            pc_d   = (pc_q + PC_STEP) & ADDR_MASK;
          end
        end
        DRAIN: begin
          imem_req  = 1'b1;
          imem_addr = drain_addr_q;
        end
        default: ;
      endcase
      if (redir) begin
        pc_ena = 1'b1;
        pc_d   = redirect_pc & ADDR_MASK;
      end
    end
  end

  assign inst_valid = rst && (fifo_cnt != 2'd0);
  assign inst       = rst ? head_ent.inst : '0;
  assign inst_pc    = rst ? head_ent.pc : '0;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios plus randomized traffic against a queue-based model.
// The bench also plays the PC register and the instruction memory.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_q = 32'h1357_9BDF;
  logic [31:0] pc_d;
  logic        pc_ena;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  int checks = 0;
  int errors = 0;

  // Reference model: booting flag, pending discard of a stale fetch, PC and a queue of {pc, inst}.
  bit          m_boot;
  bit          m_disc;
  logic [31:0] m_old;
  logic [31:0] m_pc = 32'h1357_9BDF;
  logic [63:0] m_q[$];
  logic        e_ena, e_req, e_vld;
  logic [31:0] e_pd, e_addr, e_inst, e_ipc;

  pc_fetch_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .pc_q        (pc_q),
    .pc_d        (pc_d),
    .pc_ena      (pc_ena),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_pc     (inst_pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (pc_ena) pc_q <= pc_d;

  function automatic void model_reset();
    m_boot = 1'b1;
    m_disc = 1'b0;
    m_q.delete();
  endfunction

  function automatic void model_comb();
    e_ena = 1'b0; e_pd = '0; e_req = 1'b0; e_addr = '0;
    e_vld = 1'b0; e_inst = '0; e_ipc = '0;
    if (rst) begin
      if (m_boot) begin
        e_ena = 1'b1;
        e_pd  = RST_PC;
      end else begin
        e_vld = (m_q.size() != 0);
        if (e_vld) begin
          e_ipc  = m_q[0][63:32];
          e_inst = m_q[0][31:0];
        end
        e_req  = m_disc || (m_q.size() < 2);
        e_addr = e_req ? (m_disc ? m_old : m_pc) : 32'h0;
        if (redirect) begin
          e_ena = 1'b1;
          e_pd  = {redirect_pc[31:2], 2'b00};
        end else if (!m_disc && e_req && imem_ack) begin
          e_ena = 1'b1;
          e_pd  = m_pc + 32'd4;
        end
      end
    end
  endfunction

  function automatic void model_seq();
    if (!rst) return;
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (redirect) begin
      m_q.delete();
      if (m_disc) begin
        if (imem_ack) m_disc = 1'b0;
      end else if (e_req && !imem_ack) begin
        m_disc = 1'b1;
        m_old  = m_pc;
      end
    end else if (m_disc) begin
      if (imem_ack) m_disc = 1'b0;
    end else begin
      if (e_vld && inst_ready) void'(m_q.pop_front());
      if (e_req && imem_ack) m_q.push_back({m_pc, imem_rdata});
    end
    if (e_ena) m_pc = e_pd;
  endfunction

  // Called at a negedge: apply inputs for this cycle, ack only when a request is expected.
  task automatic drive(input bit ack_w, input bit rdy, input bit redir, input logic [31:0] rpc);
    inst_ready  = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    model_comb();
    imem_ack    = ack_w && e_req;
    imem_rdata  = $urandom;
    model_comb();
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_seq();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    drive(0, 0, 0, 32'h0);
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    drive(0, 1, 1, 32'hABCD_0000);
    checks++; if (pc_ena !== 1'b0) begin errors++; $display("FAIL reset_pc_ena: got %b want 0", pc_ena); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_imem_req: got %b want 0", imem_req); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid: got %b want 0", inst_valid); end
    checks++; if (pc_d !== 32'h0 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL reset_addr: pc_d %h imem_addr %h want 0", pc_d, imem_addr);
    end
    checks++; if (inst !== 32'h0 || inst_pc !== 32'h0) begin
      errors++; $display("FAIL reset_inst: inst %h inst_pc %h want 0", inst, inst_pc);
    end
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_stream();
    logic [31:0] want;
    drive(1, 1, 0, 32'h0);
    checks++; if (pc_ena !== 1'b1 || pc_d !== RST_PC) begin
      errors++; $display("FAIL boot_load: pc_ena %b pc_d %h want 1 %h", pc_ena, pc_d, RST_PC);
    end
    tick();
    for (int c = 0; c < 6; c++) begin
      drive(1, 1, 0, 32'h0);
      checks++; if ({pc_ena, pc_d, imem_req, imem_addr} !== {e_ena, e_pd, e_req, e_addr}) begin
        errors++; $display("FAIL stream_ctl c%0d: ena %b pc_d %h req %b addr %h want %b %h %b %h",
                           c, pc_ena, pc_d, imem_req, imem_addr, e_ena, e_pd, e_req, e_addr);
      end
      if (c >= 1 && c <= 3) begin
        want = RST_PC + 32'd4 * (c - 1);
        checks++; if (inst_valid !== 1'b1 || inst_pc !== want) begin
          errors++; $display("FAIL stream_inst_pc c%0d: valid %b pc %h want 1 %h", c, inst_valid, inst_pc, want);
        end
      end
      tick();
    end
  endtask

  task automatic test_hold();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      drive(1, 0, 0, 32'h0);
      tick();
    end
    drive(1, 1, 0, 32'h0);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hold_req: got %b want 0", imem_req); end
    checks++; if (pc_q !== RST_PC + 32'd8) begin errors++; $display("FAIL hold_pc_q: got %h want %h", pc_q, RST_PC + 32'd8); end
    checks++; if (inst_valid !== 1'b1 || inst_pc !== RST_PC) begin
      errors++; $display("FAIL hold_head0: valid %b pc %h want 1 %h", inst_valid, inst_pc, RST_PC);
    end
    tick();
    drive(1, 1, 0, 32'h0);
    checks++; if (imem_req !== 1'b1 || imem_addr !== RST_PC + 32'd8) begin
      errors++; $display("FAIL hold_resume: req %b addr %h want 1 %h", imem_req, imem_addr, RST_PC + 32'd8);
    end
    checks++; if (inst_valid !== 1'b1 || inst_pc !== RST_PC + 32'd4) begin
      errors++; $display("FAIL hold_head1: valid %b pc %h want 1 %h", inst_valid, inst_pc, RST_PC + 32'd4);
    end
    tick();
  endtask

  task automatic test_late_redirect();
    do_reset();
    drive(0, 1, 0, 32'h0);
    tick();
    drive(0, 1, 1, 32'h0000_1003);
    checks++; if (pc_ena !== 1'b1 || pc_d !== 32'h0000_1000) begin
      errors++; $display("FAIL late_redir_pc_d: ena %b pc_d %h want 1 00001000", pc_ena, pc_d);
    end
    checks++; if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
      errors++; $display("FAIL late_redir_addr: req %b addr %h want 1 %h", imem_req, imem_addr, RST_PC);
    end
    tick();
    drive(0, 1, 0, 32'h0);
    checks++; if (imem_req !== 1'b1 || imem_addr !== RST_PC || pc_ena !== 1'b0) begin
      errors++; $display("FAIL drain_wait: req %b addr %h ena %b want 1 %h 0", imem_req, imem_addr, pc_ena, RST_PC);
    end
    tick();
    drive(1, 1, 0, 32'h0);
    checks++; if (imem_addr !== RST_PC || pc_ena !== 1'b0 || inst_valid !== 1'b0) begin
      errors++; $display("FAIL drain_ack: addr %h ena %b valid %b want %h 0 0", imem_addr, pc_ena, inst_valid, RST_PC);
    end
    tick();
    drive(0, 1, 0, 32'h0);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_1000 || inst_valid !== 1'b0) begin
      errors++; $display("FAIL after_drain: req %b addr %h valid %b want 1 00001000 0", imem_req, imem_addr, inst_valid);
    end
    tick();
    drive(1, 1, 0, 32'h0);
    tick();
    drive(0, 1, 0, 32'h0);
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0000_1000) begin
      errors++; $display("FAIL target_inst: valid %b pc %h want 1 00001000", inst_valid, inst_pc);
    end
    tick();
  endtask

  task automatic test_redirect_full();
    do_reset();
    drive(1, 0, 0, 32'h0);
    tick();
    drive(1, 0, 0, 32'h0);
    tick();
    drive(1, 1, 1, 32'h0000_2000);
    checks++; if (pc_ena !== 1'b1 || pc_d !== 32'h0000_2000 || inst_valid !== 1'b1) begin
      errors++; $display("FAIL redir_ack: ena %b pc_d %h valid %b want 1 00002000 1", pc_ena, pc_d, inst_valid);
    end
    tick();
    drive(0, 1, 0, 32'h0);
    checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_2000) begin
      errors++; $display("FAIL redir_flush: valid %b req %b addr %h want 0 1 00002000", inst_valid, imem_req, imem_addr);
    end
    tick();
  endtask

  task automatic test_wrap();
    drive(1, 1, 1, 32'hFFFF_FFFC);
    tick();
    drive(1, 1, 0, 32'h0);
    checks++; if (imem_addr !== 32'hFFFF_FFFC || pc_ena !== 1'b1 || pc_d !== 32'h0) begin
      errors++; $display("FAIL wrap_top: addr %h ena %b pc_d %h want fffffffc 1 0", imem_addr, pc_ena, pc_d);
    end
    tick();
    drive(1, 1, 0, 32'h0);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL wrap_zero: req %b addr %h want 1 0", imem_req, imem_addr);
    end
    tick();
  endtask

  task automatic test_reset_midfetch();
    drive(0, 0, 0, 32'h0);
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL midfetch_pre: req %b want 1", imem_req); end
    #2 rst = 1'b0;
    #1;
    checks++; if ({imem_req, inst_valid, pc_ena} !== 3'b000) begin
      errors++; $display("FAIL midfetch_async: req %b valid %b ena %b want 0 0 0", imem_req, inst_valid, pc_ena);
    end
    model_reset();
    tick();
    tick();
    rst = 1'b1;
    drive(1, 1, 0, 32'h0);
    checks++; if (pc_ena !== 1'b1 || pc_d !== RST_PC) begin
      errors++; $display("FAIL reboot_load: ena %b pc_d %h want 1 %h", pc_ena, pc_d, RST_PC);
    end
    tick();
    drive(1, 1, 0, 32'h0);
    checks++; if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
      errors++; $display("FAIL reboot_fetch: req %b addr %h want 1 %h", imem_req, imem_addr, RST_PC);
    end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] rpc;
    for (int c = 0; c < 600; c++) begin
      rpc = ($urandom_range(0, 99) < 20) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      drive($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 8, rpc);
      checks++; if (pc_ena !== e_ena || pc_d !== e_pd) begin
        errors++; $display("FAIL rand_pc c%0d: ena %b pc_d %h want %b %h", c, pc_ena, pc_d, e_ena, e_pd);
      end
      checks++; if (imem_req !== e_req || imem_addr !== e_addr) begin
        errors++; $display("FAIL rand_imem c%0d: req %b addr %h want %b %h", c, imem_req, imem_addr, e_req, e_addr);
      end
      checks++; if (inst_valid !== e_vld || (e_vld && (inst !== e_inst || inst_pc !== e_ipc))) begin
        errors++; $display("FAIL rand_inst c%0d: valid %b inst %h pc %h want %b %h %h",
                           c, inst_valid, inst, inst_pc, e_vld, e_inst, e_ipc);
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_stream();
    test_hold();
    test_late_redirect();
    test_redirect_full();
    test_wrap();
    test_reset_midfetch();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
